// File: rtl/asconp_lut_iter_if.sv
// Handshake, state and LUT-programming bundle for the iterative Ascon-p engine.
// ASCONP_SBOX_READBACK_EN adds the registered LUT read port.
interface asconp_lut_iter_if;
    logic        start_i;
    logic [3:0]  nr_i;
    logic [63:0] x0_i;
    logic [63:0] x1_i;
    logic [63:0] x2_i;
    logic [63:0] x3_i;
    logic [63:0] x4_i;
    logic        ready_o;
    logic        done_o;
    logic [63:0] x0_o;
    logic [63:0] x1_o;
    logic [63:0] x2_o;
    logic [63:0] x3_o;
    logic [63:0] x4_o;
    logic        sbox_we_i;
    logic [4:0]  sbox_addr_i;
    logic [4:0]  sbox_wdata_i;
`ifdef ASCONP_SBOX_READBACK_EN
    logic [4:0]  sbox_raddr_i;
    logic [4:0]  sbox_rdata_o;
`endif

    modport master (
        output start_i, nr_i, x0_i, x1_i, x2_i, x3_i, x4_i,
        output sbox_we_i, sbox_addr_i, sbox_wdata_i,
`ifdef ASCONP_SBOX_READBACK_EN
        output sbox_raddr_i,
        input  sbox_rdata_o,
`endif
        input  ready_o, done_o, x0_o, x1_o, x2_o, x3_o, x4_o
    );

    modport slave (
        input  start_i, nr_i, x0_i, x1_i, x2_i, x3_i, x4_i,
        input  sbox_we_i, sbox_addr_i, sbox_wdata_i,
`ifdef ASCONP_SBOX_READBACK_EN
        input  sbox_raddr_i,
        output sbox_rdata_o,
`endif
        output ready_o, done_o, x0_o, x1_o, x2_o, x3_o, x4_o
    );
endinterface

// File: rtl/asconp_lut_iter.sv
// Iterative Ascon-p permutation, UROL rounds/clock, reprogrammable 32x5 S-box LUT.
// Optional LUT readback port enabled by ASCONP_SBOX_READBACK_EN.
module asconp_lut_iter #(
    parameter int UROL       = 1,
    parameter int MAX_ROUNDS = 12
) (
    input logic               clk,
    input logic               rst_n,
    asconp_lut_iter_if.slave  bus
);
    typedef logic [4:0][63:0] st_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [4:0] SBOX_INIT [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    state_t     state;
    logic [3:0] rnd;
    logic       ready;
    logic       done;
    st_t        x;
    logic [4:0] lut [32];

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic st_t round_f(input st_t s, input logic [3:0] r,
                                    input logic [4:0] tbl [32]);
        st_t        t;
        st_t        o;
        logic [4:0] v;
        s[2][7:0] = s[2][7:0] ^ {4'hF - r, r};
        for (int j = 0; j < 64; j++) begin
            v = tbl[{s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]}];
            t[0][j] = v[4];
            t[1][j] = v[3];
            t[2][j] = v[2];
            t[3][j] = v[1];
            t[4][j] = v[0];
        end
        o[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
        o[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
        o[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
        o[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
        o[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
        return o;
    endfunction

    // Stages past round 11 pass the state through untouched.
    st_t chain [UROL+1];
    always_comb begin
        chain[0] = x;
        for (int u = 0; u < UROL; u++) begin
            if (int'(rnd) + u < 12)
                chain[u+1] = round_f(chain[u], 4'(int'(rnd) + u), lut);
            else
                chain[u+1] = chain[u];
        end
    end

    logic [4:0] r_sum;
    logic [3:0] r_next;
    logic [3:0] n_clamp;
    assign r_sum   = {1'b0, rnd} + 5'(UROL);
    assign r_next  = (r_sum >= 5'd12) ? 4'd12 : r_sum[3:0];
    assign n_clamp = (bus.nr_i > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : bus.nr_i;

`ifdef ASCONP_SBOX_READBACK_EN
    logic [4:0] rdata;
    always_ff @(posedge clk) begin
        if (!rst_n) rdata <= '0;
        else        rdata <= lut[bus.sbox_raddr_i];
    end
    assign bus.sbox_rdata_o = rdata;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rnd   <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
            x     <= '0;
            lut   <= SBOX_INIT;
        end else begin
            done <= 1'b0;
            if (ready && bus.sbox_we_i)
                lut[bus.sbox_addr_i] <= bus.sbox_wdata_i;
            unique case (state)
                IDLE: begin
                    if (bus.start_i && ready) begin
                        x     <= {bus.x4_i, bus.x3_i, bus.x2_i,
                                  bus.x1_i, bus.x0_i};
                        rnd   <= 4'd12 - n_clamp;
                        ready <= 1'b0;
                        if (n_clamp == 4'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    x   <= chain[UROL];
                    rnd <= r_next;
                    if (r_next == 4'd12) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready_o = ready;
    assign bus.done_o  = done;
    assign bus.x0_o    = x[0];
    assign bus.x1_o    = x[1];
    assign bus.x2_o    = x[2];
    assign bus.x3_o    = x[3];
    assign bus.x4_o    = x[4];
endmodule
